// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch front-end bus bundle: IMEM request/response, redirect and core instruction channels
//
// Purpose: groups every handshake/bus signal of the fetch unit so the design and its
// environment connect through one port.
// Modports:
//   master - the fetch unit: drives mem_req_*, inst_*; samples mem_rsp_*, redirect_*, inst_ready
//   slave  - the environment (IMEM + core): the reverse directions
interface fetch_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front-end with credit-limited IMEM requests and redirect flush
//
// Purpose: issues word fetches to IMEM, buffers in-order responses with their PCs and
// presents them to the core; a redirect flushes the buffer and drops stale responses.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_unit_if.master: IMEM request/response, redirect, instruction output
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          req_valid_q, req_valid_d;
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;

  logic [31:0]   buf_data_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q   [BUF_DEPTH];

  logic          req_fire, rsp_ok, push, pop;
  logic [31:0]   target_pc;
  logic          unused_pc_bits;

  assign target_pc      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    req_fire = req_valid_q & bus.mem_req_ready;
    // A response with nothing outstanding is a protocol error: ignore it entirely.
    rsp_ok   = bus.mem_rsp_valid & (in_flight_q != '0);
    pop      = inst_valid_q & bus.inst_ready & ~bus.redirect_valid;
    push     = rsp_ok & (drop_cnt_q == '0) & ~bus.redirect_valid;

    in_flight_d  = in_flight_q + CW'(req_fire) - CW'(rsp_ok);
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    drop_cnt_d   = drop_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    if (bus.redirect_valid) begin
      fetch_pc_d   = target_pc;
      rsp_pc_d     = target_pc;
      // Everything still outstanding after this edge is stale, including a request
      // accepted right now; a response arriving now is already excluded.
      drop_cnt_d   = in_flight_d;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      inst_valid_d = 1'b0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d      = count_q + CW'(push) - CW'(pop);
      inst_valid_d = (count_d != '0);
      // Head registers load the next head; the entry being written this cycle is not
      // in the array yet, so take it straight from the response when it becomes head.
      if (count_d != '0) begin
        if (push && wr_ptr_q == rd_ptr_d) begin
          inst_d    = bus.mem_rsp_data;
          inst_pc_d = rsp_pc_q;
        end else begin
          inst_d    = buf_data_q[rd_ptr_d];
          inst_pc_d = buf_pc_q[rd_ptr_d];
        end
      end
    end

    // Credit rule: outstanding requests plus buffered entries never exceed the buffer.
    req_valid_d = ({1'b0, in_flight_d} + {1'b0, count_d}) < DEPTH_W;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      in_flight_q  <= '0;
      drop_cnt_q   <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      in_flight_q  <= in_flight_d;
      drop_cnt_q   <= drop_cnt_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= bus.mem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with an in-order IMEM model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  int n_tests = 0;
  int n_fail  = 0;
  ent_t exp_q[$];
  req_t pend[$];
  logic [31:0] exp_req_addr = 32'h0;
  int pops = 0;
  int fires = 0;
  int cyc = 0;
  int lat = 1;
  logic acc_flag = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e.pc   = start + 32'(4 * i);
      e.data = mdata(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pops < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (pops < n) begin
      n_fail++;
      $display("FAIL wait_pops: got %0d pops expected %0d", pops, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_req_addr = 32'h0;
    pops  = 0;
    fires = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: checks request addresses and pops the scoreboard on every consumed instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        chk("req_addr", bus.mem_req_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        fires++;
        acc_flag = 1'b1;
        acc_addr = bus.mem_req_addr;
      end
      if (bus.redirect_valid) exp_req_addr = {bus.redirect_pc[31:2], 2'b00};
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h expected none", bus.inst_pc);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("inst_pc", bus.inst_pc, e.pc);
          chk("inst", bus.inst, e.data);
        end
      end
    end
  end

  // IMEM model: in-order responses lat cycles after acceptance, no back-pressure.
  always begin
    req_t r;
    @(posedge clk); #1;
    if (rst) begin
      pend.delete();
      acc_flag = 1'b0;
      bus.mem_rsp_valid = 1'b0;
    end else begin
      cyc++;
      if (acc_flag) begin
        r.addr = acc_addr;
        r.due  = cyc + lat;
        pend.push_back(r);
        acc_flag = 1'b0;
      end
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        r = pend.pop_front();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mdata(r.addr);
      end else begin
        bus.mem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    int p0;
    int k;
    rst = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b1;
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);

    // Streaming, 1-cycle IMEM
    lat = 1;
    do_reset();
    push_seq(32'h0, 64);
    @(negedge clk);
    chk("first_cycle_req_valid", 32'(bus.mem_req_valid), 32'd0);
    @(negedge clk);
    chk("second_cycle_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("second_cycle_req_addr", bus.mem_req_addr, 32'h0);
    @(posedge clk); #1;
    k = 0;
    while (!bus.inst_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    p0 = pops;
    repeat (10) @(posedge clk);
    #1 chk("throughput", 32'(pops - p0), 32'd10);
    wait_pops(20);

    // Core stall: credit cap of 4
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    chk("stall_fires", 32'(fires), 32'd4);
    chk("stall_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
    push_seq(32'h0, 64);
    bus.inst_ready = 1'b1;
    wait_pops(8);

    // IMEM not ready for 3 cycles
    bus.mem_req_ready = 1'b0;
    do_reset();
    push_seq(32'h0, 64);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("hold_req_addr", bus.mem_req_addr, 32'h0);
      @(posedge clk); #1;
    end
    chk("hold_fires", 32'(fires), 32'd0);
    bus.mem_req_ready = 1'b1;
    wait_pops(4);

    // Redirect with 2 in flight plus 1 accepted same cycle, 3-cycle IMEM
    lat = 3;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    exp_q.delete();
    push_seq(32'h0000_0100, 64);
    @(negedge clk);
    chk("redir_same_cycle_fire", 32'(bus.mem_req_valid & bus.mem_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    chk("redir_next_addr", bus.mem_req_addr, 32'h0000_0100);
    wait_pops(6);

    // Back-to-back redirects, last wins
    lat = 2;
    do_reset();
    push_seq(32'h0, 64);
    repeat (5) @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    exp_q.delete();
    @(posedge clk); #1;
    bus.redirect_pc = 32'h0000_0300;
    push_seq(32'h0000_0300, 64);
    p0 = pops;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    wait_pops(p0 + 6);

    // Redirect near the top of the address space: PC wraps to 0
    lat = 1;
    do_reset();
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF9;
    push_seq(32'hFFFF_FFF8, 64);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    wait_pops(6);

    // Async reset pulse between edges
    lat = 1;
    do_reset();
    push_seq(32'h0, 64);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("pre_rst_req_valid", 32'(bus.mem_req_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    do_reset();
    push_seq(32'h0, 64);
    @(negedge clk);
    @(negedge clk);
    chk("restart_req_addr", bus.mem_req_addr, 32'h0);
    @(posedge clk); #1;
    wait_pops(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end sitting directly upstream of the single-cycle/decode core.
- Issues word requests to an instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words with their PCs and presents them to the core over a valid/ready channel.
- Handles PC redirects (taken branch/jump) by flushing the buffer and discarding stale in-flight responses.

Parameters:
RESET_PC  32'h0000_0000  first fetch address after reset
BUF_DEPTH  4  instruction buffer entries; also the cap on requests in flight plus buffered entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
mem_req_valid  output  1  request to IMEM valid
mem_req_ready  input  1  IMEM accepts request
mem_req_addr  output  32  word-aligned fetch address
mem_rsp_valid  input  1  response data valid (in order, no back-pressure)
mem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  core redirects fetch this cycle
redirect_pc  input  32  new fetch PC ([1:0] ignored)
inst_valid  output  1  buffer head valid to core
inst_ready  input  1  core consumes head
inst  output  32  head instruction
inst_pc  output  32  head instruction PC

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC.
  - in_flight = 0, drop_cnt = 0, buffer empty.
  - mem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0.
- Handshake events:
  - req_fire = mem_req_valid & mem_req_ready.
  - rsp_fire = mem_rsp_valid.
  - pop = inst_valid & inst_ready.
- Request issue:
  - mem_req_valid = (in_flight + count < BUF_DEPTH), from registered state only. It never depends on redirect_valid or inst_ready in the same cycle.
  - mem_req_addr = fetch_pc.
  - Each req_fire: fetch_pc += 4 (32-bit wrap from FFFF_FFFC to 0000_0000).
  - mem_req_valid/addr hold stable while ready = 0.
- In-flight count: in_flight_next = in_flight + req_fire - rsp_fire.
- Response accept (in order):
  - If drop_cnt != 0: discard the response and decrement drop_cnt.
  - Else if redirect_valid: discard.
  - Else: push {rsp_pc, mem_rsp_data} into the buffer and rsp_pc += 4.
  - Space is guaranteed by the credit rule; a push never overflows.
- Output:
  - inst_valid = buffer non-empty; inst/inst_pc = head entry, driven from registers.
  - When inst_valid = 0, inst and inst_pc hold their last values.
  - pop removes the head. Push and pop in the same cycle is legal when count is unchanged or full.
- Latency: earliest request is the cycle after reset deasserts. Response can arrive >=1 cycle after accept. inst_valid rises the cycle after an accepted response (no bypass).
- Redirect (redirect_valid = 1, priority over all else):
  - Buffer flushed next cycle; any pop in this cycle is irrelevant.
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2], 2'b00}.
  - drop_cnt = in_flight_next. This counts a request accepted in the same cycle as stale, and excludes a response received this cycle.
  - Back-to-back redirects: each recomputes drop_cnt the same way; the last redirect wins.
- Error cases:
  - mem_rsp_valid with in_flight = 0 is a protocol error; the response is ignored and counters do not underflow.
  - Reset asserted mid-operation discards all state. IMEM is reset concurrently, so no pre-reset responses return.

Test Plan:
- Reset release, IMEM 1-cycle latency, always ready, inst_ready = 1 -> requests at 0x0, 0x4, 0x8, ...; inst_pc sequence 0x0, 0x4, 0x8 with matching data; throughput 1 inst/cycle in steady state.
- inst_ready = 0 for 10 cycles -> exactly 4 (BUF_DEPTH) requests issued, mem_req_valid = 0 after that; on release, 4 instructions drain in order with no loss or duplication.
- mem_req_ready = 0 for 3 cycles -> mem_req_addr stays 0x0, no fetch_pc advance.
- Redirect to 0x103 with 2 requests in flight (3-cycle IMEM latency) and 1 request accepted the same cycle -> next request address 0x100, 3 responses dropped, first inst_pc = 0x100, no stale inst ever shown.
- Redirect on 2 consecutive cycles (0x200, then 0x300) -> only instructions from 0x300 onward appear.
- Async rst pulse mid-stream (between clock edges) -> inst_valid = 0 and mem_req_valid = 0 immediately; fetch restarts at RESET_PC.
